// File: rtl/fifo_push_arbiter_pkg.sv
// rtl/fifo_push_arbiter_pkg.sv - shared types, constants and parity helper for fifo_push_arbiter
//
// Purpose : slot-state enum, drop counter width and the parity check used by
//           the optional parity-drop path (FIFO_ARB_PARITY_DROP_EN).
// Ports   : none (package).

package fifo_arb_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_e;

   localparam int DROP_CNT_W = 16;

   // Callers zero-extend their word to this width; zero padding does not
   // change the XOR-reduction, so one function serves every DATA_WIDTH.
   localparam int PARITY_MAX_W = 1024;

   function automatic logic parity_ok(input logic [PARITY_MAX_W-1:0] word,
                                      input logic                    even_odd);
      return ((^word) == even_odd);
   endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr_picker.sv
// rtl/fifo_push_arbiter_rr_picker.sv - combinational round-robin winner search
//
// Purpose : picks the first set request at or above ptr_i, wrapping past
//           N_REQ-1 back to 0.
// Ports   : req_i    - request vector
//           ptr_i    - search start index (always < N_REQ)
//           onehot_o - one-hot winner (zero when no request)
//           idx_o    - winner index (zero when no request)
//           any_o    - at least one request is set

module rr_picker #(
   parameter int N_REQ = 4,
   parameter int PTR_W = 2
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N_REQ-1:0] onehot_o,
   output logic [PTR_W-1:0] idx_o,
   output logic             any_o
);

   always_comb begin : pick
      int               cand;
      logic [PTR_W-1:0] cand_idx;
      onehot_o = '0;
      idx_o    = '0;
      any_o    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      // Walk offsets from farthest to nearest so the nearest hit (the
      // round-robin winner) is the last assignment and therefore sticks.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand     = (int'(ptr_i) + k) % N_REQ;
         cand_idx = PTR_W'(cand);
         if (req_i[cand_idx]) begin
            onehot_o           = '0;
            onehot_o[cand_idx] = 1'b1;
            idx_o              = cand_idx;
            any_o              = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_push_arbiter.sv
// rtl/fifo_push_arbiter.sv - round-robin N-to-1 push arbiter with a one-word output slot
//
// Purpose : grants one requester per cycle (round-robin) and registers its
//           word into a single output slot feeding a FIFO. Optional feature
//           macro FIFO_ARB_PARITY_DROP_EN discards parity-failed words after
//           the handshake and counts them.
// Ports   : clk, rst        - clock, asynchronous active-high reset
//           req_valid_i     - per-requester valid
//           req_data_i      - per-requester word (DATA_WIDTH+1 bits)
//           req_grant_o     - one-hot grant (zero when nothing accepted)
//           fifo_valid_o    - output slot is FULL
//           fifo_data_o     - registered output word
//           fifo_grant_i    - FIFO accepts the slot word this cycle
//           drop_cnt_o      - saturating count of parity-dropped words

module fifo_push_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int N_REQ      = 4,
   parameter int EVEN_ODD   = 0
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [N_REQ-1:0]                  req_valid_i,
   input  logic [N_REQ-1:0][DATA_WIDTH:0]    req_data_i,
   output logic [N_REQ-1:0]                  req_grant_o,
   output logic                              fifo_valid_o,
   output logic [DATA_WIDTH:0]               fifo_data_o,
   input  logic                              fifo_grant_i,
   output logic [DROP_CNT_W-1:0]             drop_cnt_o
);

   localparam int PTR_W = $clog2(N_REQ);

   slot_state_e       slot_q, slot_d;
   logic [DATA_WIDTH:0] data_q, data_d;
   logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;

   logic [N_REQ-1:0]  win_onehot;
   logic [PTR_W-1:0]  win_idx;
   logic              win_any;
   logic              can_accept;
   logic              accept;
   logic              load;
   logic [DATA_WIDTH:0] win_word;

   rr_picker #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_picker (
      .req_i    (req_valid_i),
      .ptr_i    (rr_ptr_q),
      .onehot_o (win_onehot),
      .idx_o    (win_idx),
      .any_o    (win_any)
   );

   // A FULL slot can be refilled on the same edge it drains. rst gates
   // accept so no grant is visible while reset is held.
   always_comb begin
      can_accept = (slot_q == EMPTY) || fifo_grant_i;
      accept     = win_any && can_accept && !rst;
      win_word   = req_data_i[win_idx];
   end

`ifdef FIFO_ARB_PARITY_DROP_EN
   logic [PARITY_MAX_W-1:0] word_ext;
   logic                    drop;
   logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

   // A dropped word still completes its handshake (grant and pointer move)
   // but never reaches the slot.
   always_comb begin
      word_ext                = '0;
      word_ext[DATA_WIDTH:0]  = win_word;
      drop                    = accept && !parity_ok(word_ext, (EVEN_ODD != 0));
      load                    = accept && !drop;
      drop_cnt_d              = drop_cnt_q;
      if (drop && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt_o = drop_cnt_q;
`else
   assign load       = accept;
   assign drop_cnt_o = '0;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_q   <= EMPTY;
         data_q   <= '0;
         rr_ptr_q <= '0;
      end else begin
         slot_q   <= slot_d;
         data_q   <= data_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // Next-state logic
   always_comb begin
      slot_d = slot_q;
      case (slot_q)
         EMPTY:   if (load) slot_d = FULL;
         FULL:    if (fifo_grant_i && !load) slot_d = EMPTY;
         default: slot_d = EMPTY;
      endcase
   end

   // Datapath next values: slot word changes only on load, pointer only on accept
   always_comb begin
      data_d   = load ? win_word : data_q;
      rr_ptr_d = rr_ptr_q;
      if (accept) begin
         rr_ptr_d = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
      end
   end

   // Outputs: fifo_valid_o is purely registered
   always_comb begin
      fifo_valid_o = (slot_q == FULL);
      fifo_data_o  = data_q;
      req_grant_o  = accept ? win_onehot : '0;
   end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb/tb_fifo_push_arbiter.sv - self-checking bench for fifo_push_arbiter

module tb_fifo_push_arbiter;

   localparam int DW = 32;
   localparam int N  = 4;
`ifdef FIFO_ARB_PARITY_DROP_EN
   localparam bit DROP_EN = 1'b1;
`else
   localparam bit DROP_EN = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  rst;
   logic [N-1:0]          req_valid;
   logic [N-1:0][DW:0]    req_data;
   logic [N-1:0]          req_grant;
   logic                  fifo_valid;
   logic [DW:0]           fifo_data;
   logic                  fifo_grant;
   logic [15:0]           drop_cnt;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   int          m_ptr;
   bit          m_full;
   logic [DW:0] m_data;
   int          m_drop;
   logic [DW:0] sb_q[$];
   logic [N-1:0] exp_grant;
   int          exp_win;
   logic [N-1:0] last_grant;
   logic [DW:0] last_data;

   // Random-phase requester holding registers
   logic [N-1:0]       pend_valid;
   logic [N-1:0][DW:0] pend_data;
   int                 seq;

   fifo_push_arbiter #(
      .DATA_WIDTH (DW),
      .N_REQ      (N),
      .EVEN_ODD   (0)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (req_valid),
      .req_data_i   (req_data),
      .req_grant_o  (req_grant),
      .fifo_valid_o (fifo_valid),
      .fifo_data_o  (fifo_data),
      .fifo_grant_i (fifo_grant),
      .drop_cnt_o   (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit par_good(input logic [DW:0] w);
      return ((^w) == 1'b0);
   endfunction

   task automatic model_reset();
      m_ptr  = 0;
      m_full = 1'b0;
      m_data = '0;
      m_drop = 0;
      sb_q.delete();
   endtask

   // Expected winner from the rules: first valid requester searching up from
   // the pointer with wrap, only if the slot can take a word.
   task automatic predict();
      int i;
      exp_grant = '0;
      exp_win   = -1;
      if (!rst && (!m_full || fifo_grant)) begin
         for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (exp_win < 0 && req_valid[i]) exp_win = i;
         end
      end
      if (exp_win >= 0) exp_grant[exp_win] = 1'b1;
   endtask

   task automatic step(input string tag);
      bit          fwd;
      logic [DW:0] w;
      @(negedge clk);
      predict();
      last_grant = req_grant;
      last_data  = fifo_data;
      check({tag, ".grant"}, req_grant, exp_grant);
      check({tag, ".valid"}, fifo_valid, m_full);
      check({tag, ".data"},  fifo_data, m_data);
      check({tag, ".drop"},  drop_cnt, m_drop);
      if (!rst && fifo_valid && fifo_grant) begin
         if (sb_q.size() == 0) begin
            check({tag, ".sb_unexpected_push"}, fifo_data, 64'hDEAD_BEEF_0000_0000);
         end else begin
            check({tag, ".sb_order"}, fifo_data, sb_q[0]);
            void'(sb_q.pop_front());
         end
      end
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         fwd = 1'b0;
         w   = '0;
         if (exp_win >= 0) begin
            m_ptr = (exp_win + 1) % N;
            w     = req_data[exp_win];
            if (DROP_EN && !par_good(w)) begin
               if (m_drop < 16'hFFFF) m_drop++;
            end else begin
               fwd = 1'b1;
            end
         end
         if (fwd) begin
            m_full = 1'b1;
            m_data = w;
            sb_q.push_back(w);
         end else if (m_full && fifo_grant) begin
            m_full = 1'b0;
         end
      end
      #1;
   endtask

   initial begin
      logic [N-1:0] seq_exp [5];
      seq_exp[0] = 4'b0001; seq_exp[1] = 4'b0010; seq_exp[2] = 4'b0100;
      seq_exp[3] = 4'b1000; seq_exp[4] = 4'b0001;

      // Reset with all requesters valid: no grant may leak out
      rst        = 1'b1;
      req_valid  = 4'b1111;
      req_data   = '0;
      fifo_grant = 1'b0;
      model_reset();
      #1;
      step("reset");
      step("reset");
      check("reset.grant_zero", last_grant, 4'b0000);
      check("reset.data_zero",  last_data, 0);
      rst = 1'b0;

      // Round-robin over four always-valid requesters
      req_data[0] = 33'h3; req_data[1] = 33'h5; req_data[2] = 33'h6; req_data[3] = 33'h9;
      fifo_grant  = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step("rr");
         check("rr.sequence", last_grant, seq_exp[k]);
      end

      // Stall with 'h6 in the slot
      req_valid = 4'b0100;
      step("load6");
      fifo_grant = 1'b0;
      req_valid  = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         step("stall");
         check("stall.no_grant", last_grant, 4'b0000);
         check("stall.hold6", last_data, 33'h6);
      end
      fifo_grant = 1'b1;
      step("drain_refill");
      check("drain_refill.grant3", last_grant, 4'b1000);
      req_valid = 4'b0000;
      step("drain_refill.out");
      check("drain_refill.word9", last_data, 33'h9);

      // Single requester 3 after pointer moved to 1
      req_valid = 4'b0001;
      step("ptr1");
      req_valid = 4'b1000;
      step("only3");
      check("only3.grant", last_grant, 4'b1000);
      req_valid = 4'b1111;
      step("wrap");
      check("wrap.ptr0", last_grant, 4'b0001);

      // Odd-parity word from requester 1
      req_valid   = 4'b0010;
      req_data[1] = 33'h7;
      step("odd7");
      check("odd7.grant", last_grant, 4'b0010);
      req_valid = 4'b0000;
      step("odd7.after");
      check("odd7.drop_cnt", drop_cnt, DROP_EN ? 1 : 0);
      req_valid   = 4'b0010;
      req_data[1] = 33'h8;
      step("word8");
      req_data[1] = 33'hC;
      step("wordC");
      req_valid = 4'b0000;
      step("par.tail");
      check("par.tail.wordC", last_data, 33'hC);
      step("par.tail2");

      // Reset pulse while FULL with 'hA and the FIFO stalled
      fifo_grant  = 1'b0;
      req_valid   = 4'b0001;
      req_data[0] = 33'hA;
      step("loadA");
      req_valid = 4'b0000;
      step("holdA");
      check("holdA.data", last_data, 33'hA);
      #2;
      rst = 1'b1;
      #1;
      check("rstA.valid_now", fifo_valid, 1'b0);
      check("rstA.data_now",  fifo_data, 0);
      check("rstA.grant_now", req_grant, 4'b0000);
      model_reset();
      step("rstA.held");
      rst        = 1'b0;
      fifo_grant = 1'b1;
      for (int k = 0; k < 3; k++) step("postA");

      // Random traffic; requesters hold their word until granted
      pend_valid = '0;
      pend_data  = '0;
      seq        = 0;
      for (int c = 0; c < 200; c++) begin
         fifo_grant = 1'($urandom_range(0, 1));
         for (int i = 0; i < N; i++) begin
            if (!pend_valid[i] && ($urandom_range(0, 2) != 0)) begin
               logic [DW:0] w;
               w = {1'b0, 8'(i), 16'(seq), 8'($urandom)};
               if (!par_good(w)) w[0] = ~w[0];
               pend_valid[i] = 1'b1;
               pend_data[i]  = w;
               seq++;
            end
         end
         req_valid = pend_valid;
         req_data  = pend_data;
         step("rand");
         pend_valid = pend_valid & ~exp_grant;
      end
      req_valid  = '0;
      fifo_grant = 1'b1;
      for (int k = 0; k < 3; k++) step("flush");
      check("flush.no_loss", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
